// File: rtl/usb_spi_responder.sv
// usb_spi_responder: SPI mode-0 slave (sclk/ss/mosi in, miso out) over a 32x8 register file with W1C HIRQ(25)/HIEN(26) interrupt, host port and SPI write strobe
module usb_spi_responder #(
  parameter int CLK_PER_SCLK_MIN = 8
) (
  input  logic       Clk,
  input  logic       reset_rtl_0,
  input  logic       usb_spi_sclk,
  input  logic       usb_spi_ss,
  input  logic       usb_spi_mosi,
  output logic       usb_spi_miso,
  output logic       gpio_usb_int,
  input  logic [4:0] host_addr,
  input  logic [7:0] host_wdata,
  input  logic       host_we,
  output logic [7:0] host_rdata,
  input  logic [7:0] irq_set,
  output logic       spi_wr_valid,
  output logic [4:0] spi_wr_addr,
  output logic [7:0] spi_wr_data
);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state, state_nx;
  logic [2:0] sclk_sy, ss_sy;
  logic [1:0] mosi_sy;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sr, tx_sr, rx_byte;
  logic [4:0] addr_q;
  logic       wr_q, active, rise, fall, ss_fall, ss_rise, byte_end, spi_we;
  logic [7:0] regs [32];
  logic [7:0] regs_nx [32];
  if (CLK_PER_SCLK_MIN < 6) begin : g_chk
    $error("CLK_PER_SCLK_MIN must be at least 6");
  end
  always_ff @(posedge Clk) begin
    sclk_sy <= {sclk_sy[1:0], usb_spi_sclk};
    ss_sy   <= {ss_sy[1:0], usb_spi_ss};
    mosi_sy <= {mosi_sy[0], usb_spi_mosi};
  end
  assign active   = state != IDLE && !ss_sy[1];
  assign rise     = active && sclk_sy[1] && !sclk_sy[2];
  assign fall     = active && !sclk_sy[1] && sclk_sy[2];
  assign ss_fall  = !ss_sy[1] && ss_sy[2];
  assign ss_rise  = ss_sy[1] && !ss_sy[2];
  assign byte_end = rise && bit_cnt == 3'd7;
  assign rx_byte  = {rx_sr[6:0], mosi_sy[1]};
  assign spi_we   = byte_end && state == DATA && wr_q;
  assign usb_spi_miso = state != IDLE && tx_sr[7];
  assign host_rdata   = regs[host_addr];
  always_comb begin
    state_nx = ss_rise ? IDLE :
               (state == IDLE && ss_fall) ? CMD :
               (state == CMD && byte_end) ? DATA : state;
  end
  always_ff @(posedge Clk) begin
    if (reset_rtl_0) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_nx[i] = regs[i];
      if (host_we && host_addr == 5'(i)) regs_nx[i] = host_wdata;
      if (spi_we && addr_q == 5'(i)) regs_nx[i] = (i == 25) ? regs[i] & ~rx_byte : rx_byte;
    end
    regs_nx[25] = regs_nx[25] | irq_set;
  end
  always_ff @(posedge Clk) begin
    if (reset_rtl_0) begin
      bit_cnt      <= 3'd0;
      rx_sr        <= 8'h00;
      tx_sr        <= 8'h00;
      addr_q       <= 5'd0;
      wr_q         <= 1'b0;
      regs         <= '{default: 8'h00};
      gpio_usb_int <= 1'b1;
      spi_wr_valid <= 1'b0;
      spi_wr_addr  <= 5'd0;
      spi_wr_data  <= 8'h00;
    end else begin
      regs         <= regs_nx;
      gpio_usb_int <= ~|(regs[25] & regs[26]);
      spi_wr_valid <= spi_we;
      if (spi_we) begin
        spi_wr_addr <= addr_q;
        spi_wr_data <= rx_byte;
      end
      if (ss_rise) begin
        bit_cnt <= 3'd0;
        rx_sr   <= 8'h00;
      end else if (state == IDLE && ss_fall) begin
        bit_cnt <= 3'd0;
        rx_sr   <= 8'h00;
        tx_sr   <= regs[25];
      end else if (rise) begin
        rx_sr   <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_end && state == CMD) begin
          addr_q <= rx_byte[7:3];
          wr_q   <= rx_byte[1];
          tx_sr  <= rx_byte[1] ? 8'h00 : regs[rx_byte[7:3]];
        end else if (byte_end) begin
          tx_sr <= wr_q ? 8'h00 : regs[addr_q];
        end
      end else if (fall && bit_cnt != 3'd0) begin
        // bit_cnt==0 means the byte just reloaded TX; keep its MSB on miso
        tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end
endmodule
